// File: rtl/operand_fetch.sv
// Operand fetch stage: resolves both source operands through the EX/MEM/WB
// bypass network, detects load-use hazards and registers the issued operands.

module operand_fetch_src (
   input  logic [4:0]  rs,
   input  logic [31:0] rf_rdata,
   input  logic        ex_en,
   input  logic [4:0]  ex_rd,
   input  logic [31:0] ex_data,
   input  logic        mem_en,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_data,
   input  logic        wb_en,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        ex_hit,
   output logic [31:0] data
);
   logic mem_hit, wb_hit;

   assign ex_hit  = ex_en  & (ex_rd  == rs);
   assign mem_hit = mem_en & (mem_rd == rs);
   assign wb_hit  = wb_en  & (wb_rd  == rs);

   // WB must win over the RF: its write lands on the same edge we capture.
   always_comb begin
      data = rf_rdata;
      if (rs == 5'd0)   data = '0;
      else if (ex_hit)  data = ex_data;
      else if (mem_hit) data = mem_data;
      else if (wb_hit)  data = wb_data;
   end
endmodule

module operand_fetch #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             id_valid,
   output logic             id_ready,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             id_rd_we,
   input  logic             id_is_load,
   input  logic [31:0]      id_pc,
   output logic [4:0]       rf_raddr1,
   output logic [4:0]       rf_raddr2,
   input  logic [31:0]      rf_rdata1,
   input  logic [31:0]      rf_rdata2,
   input  logic             ex_fwd_valid,
   input  logic             ex_fwd_we,
   input  logic             ex_fwd_is_load,
   input  logic [4:0]       ex_fwd_rd,
   input  logic [31:0]      ex_fwd_data,
   input  logic             mem_fwd_valid,
   input  logic             mem_fwd_we,
   input  logic [4:0]       mem_fwd_rd,
   input  logic [31:0]      mem_fwd_data,
   input  logic             wb_fwd_valid,
   input  logic             wb_fwd_we,
   input  logic [4:0]       wb_fwd_rd,
   input  logic [31:0]      wb_fwd_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_src1,
   output logic [31:0]      out_src2,
   output logic [4:0]       out_rd,
   output logic             out_rd_we,
   output logic             out_is_load,
   output logic [31:0]      out_pc,
   output logic [CNT_W-1:0] stall_cnt
);
   localparam int NSRC = 2;

   logic [NSRC-1:0][4:0]  rs_vec;
   logic [NSRC-1:0][31:0] rf_vec;
   logic [NSRC-1:0][31:0] src_vec;
   logic [NSRC-1:0]       use_vec, ex_hit;
   logic                  hazard, capture;

   assign rf_raddr1 = id_rs1;
   assign rf_raddr2 = id_rs2;
   assign rs_vec    = {id_rs2, id_rs1};
   assign rf_vec    = {rf_rdata2, rf_rdata1};
   assign use_vec   = {id_use_rs2, id_use_rs1};

   for (genvar i = 0; i < NSRC; i++) begin : g_src
      operand_fetch_src u_src (
         .rs       (rs_vec[i]),
         .rf_rdata (rf_vec[i]),
         .ex_en    (ex_fwd_valid & ex_fwd_we),
         .ex_rd    (ex_fwd_rd),
         .ex_data  (ex_fwd_data),
         .mem_en   (mem_fwd_valid & mem_fwd_we),
         .mem_rd   (mem_fwd_rd),
         .mem_data (mem_fwd_data),
         .wb_en    (wb_fwd_valid & wb_fwd_we),
         .wb_rd    (wb_fwd_rd),
         .wb_data  (wb_fwd_data),
         .ex_hit   (ex_hit[i]),
         .data     (src_vec[i])
      );
   end

   // Load data in EX is not ready yet; use flags only gate the stall.
   assign hazard   = id_valid & ex_fwd_valid & ex_fwd_we & ex_fwd_is_load &
                     (ex_fwd_rd != 5'd0) & |(use_vec & ex_hit);
   assign id_ready = ~flush & ~hazard & (~out_valid | out_ready);
   assign capture  = id_valid & id_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_valid   <= 1'b0;
         out_src1    <= '0;
         out_src2    <= '0;
         out_rd      <= '0;
         out_rd_we   <= 1'b0;
         out_is_load <= 1'b0;
         out_pc      <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (capture) begin
         out_valid   <= 1'b1;
         out_src1    <= src_vec[0];
         out_src2    <= src_vec[1];
         out_rd      <= id_rd;
         out_rd_we   <= id_rd_we;
         out_is_load <= id_is_load;
         out_pc      <= id_pc;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         stall_cnt <= '0;
      else if (hazard && !flush && !(&stall_cnt))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end
endmodule
